// File: rtl/tl_pkg.sv
// Shared state encodings, lamp constants and timer-load helper for the
// two-road traffic light controller.
package tl_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED1   = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED2   = 3'd5,
    WALK      = 3'd6
  } state_t;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  // A zero duration is treated as one tick; the result is clipped to the timer width.
  function automatic int load_val(input int t, input int cw);
    int tt;
    tt = (t < 1) ? 1 : t;
    tt = tt - 1;
    if (tt > (1 << cw) - 1) tt = (1 << cw) - 1;
    return tt;
  endfunction

endpackage

// File: rtl/tick_sync.sv
// Two-flop synchronizer plus rising-edge detector for the divided tick input.
// A level held high yields exactly one single-cycle pulse.
module tick_sync (
  input  logic clk_in,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse_out
);

  logic s1, s2, s3;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse_out = s2 & ~s3;

endmodule

// File: rtl/traffic_light_fsm.sv
// Two-road traffic light controller with a pedestrian walk phase.
//   state     | meaning
//   NS_GREEN  | north-south green, east-west red
//   NS_YELLOW | north-south yellow, east-west red
//   ALLRED1   | clearance before east-west green
//   EW_GREEN  | east-west green, north-south red
//   EW_YELLOW | east-west yellow, north-south red
//   ALLRED2   | clearance; exits to WALK when a request is pending
//   WALK      | all red, pedestrian walk lamp on
module traffic_light_fsm
  import tl_pkg::*;
#(
  parameter int GREEN_T  = 5,
  parameter int YELLOW_T = 2,
  parameter int ALLRED_T = 1,
  parameter int WALK_T   = 4,
  parameter int CW       = 4
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] state_o
);

  localparam logic [CW-1:0] LD_GREEN  = CW'(load_val(GREEN_T, CW));
  localparam logic [CW-1:0] LD_YELLOW = CW'(load_val(YELLOW_T, CW));
  localparam logic [CW-1:0] LD_ALLRED = CW'(load_val(ALLRED_T, CW));
  localparam logic [CW-1:0] LD_WALK   = CW'(load_val(WALK_T, CW));

  state_t        state_q, state_n;
  logic [CW-1:0] timer_q, timer_n;
  logic          pending_q, pending_n;
  logic          ack_n;
  logic          tick;

  tick_sync u_tick_sync (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .async_in  (tick_in),
    .pulse_out (tick)
  );

  function automatic logic [CW-1:0] load_for(input state_t s);
    case (s)
      NS_GREEN, EW_GREEN:   return LD_GREEN;
      NS_YELLOW, EW_YELLOW: return LD_YELLOW;
      ALLRED1, ALLRED2:     return LD_ALLRED;
      WALK:                 return LD_WALK;
      default:              return LD_GREEN;
    endcase
  endfunction

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= NS_GREEN;
      timer_q   <= LD_GREEN;
      pending_q <= 1'b0;
      ped_ack   <= 1'b0;
    end else begin
      state_q   <= state_n;
      timer_q   <= timer_n;
      pending_q <= pending_n;
      ped_ack   <= ack_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    timer_n   = timer_q;
    pending_n = pending_q;
    ack_n     = 1'b0;
    if (ped_req && !pending_q && state_q != WALK) begin
      pending_n = 1'b1;
      ack_n     = 1'b1;
    end
    if (tick) begin
      if (timer_q != '0) begin
        timer_n = timer_q - 1'b1;
      end else begin
        case (state_q)
          NS_GREEN:  state_n = NS_YELLOW;
          NS_YELLOW: state_n = ALLRED1;
          ALLRED1:   state_n = EW_GREEN;
          EW_GREEN:  state_n = EW_YELLOW;
          EW_YELLOW: state_n = ALLRED2;
          // Registered pending only: a same-edge request waits a full cycle.
          ALLRED2:   state_n = pending_q ? WALK : NS_GREEN;
          WALK: begin
            state_n   = NS_GREEN;
            pending_n = 1'b0;
          end
          default:   state_n = NS_GREEN;
        endcase
        timer_n = load_for(state_n);
      end
    end
  end

  always_comb begin
    ns_light = LAMP_R;
    ew_light = LAMP_R;
    walk     = 1'b0;
    case (state_q)
      NS_GREEN:  ns_light = LAMP_G;
      NS_YELLOW: ns_light = LAMP_Y;
      EW_GREEN:  ew_light = LAMP_G;
      EW_YELLOW: ew_light = LAMP_Y;
      WALK:      walk     = 1'b1;
      default: begin
        ns_light = LAMP_R;
        ew_light = LAMP_R;
      end
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Randomized bench for traffic_light_fsm against a phase/remaining-tick model
// driven from a per-edge history of sampled tick_in levels.
module tb_traffic_light_fsm;

  localparam int G = 5, Y = 2, A = 1, W = 4;

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_in = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] ns_light, ew_light, state_o;
  logic       walk, ped_ack;

  traffic_light_fsm #(.GREEN_T(G), .YELLOW_T(Y), .ALLRED_T(A), .WALK_T(W), .CW(4)) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .tick_in  (tick_in),
    .ped_req  (ped_req),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .walk     (walk),
    .ped_ack  (ped_ack),
    .state_o  (state_o)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  int         plen[7];
  logic [2:0] ns_tab[7];
  logic [2:0] ew_tab[7];
  bit         samp[$];
  int         p, rem, cyc;
  bit         pend, ack;
  int         ack_cnt, walk_cnt;
  int         entries[$];
  logic [2:0] prev_state;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit tick_next();
    int n;
    n = samp.size();
    return samp[n-2] & ~samp[n-3];
  endfunction

  task automatic model_step(input bit r, input bit tk, input bit pr);
    bit t, new_ack, new_pend;
    if (!r) begin
      p = 0; rem = plen[0]; pend = 0; ack = 0;
      samp.push_back(1'b0);
      return;
    end
    t = tick_next();
    samp.push_back(tk);
    new_ack  = pr && !pend && p != 6;
    new_pend = pend | new_ack;
    if (t) begin
      rem--;
      if (rem == 0) begin
        if (p == 5) p = pend ? 6 : 0;
        else if (p == 6) begin p = 0; new_pend = 0; end
        else p = p + 1;
        rem = plen[p];
      end
    end
    pend = new_pend;
    ack  = new_ack;
  endtask

  task automatic check_all();
    check("state", 32'(state_o), p);
    check("ns_light", 32'(ns_light), 32'(ns_tab[p]));
    check("ew_light", 32'(ew_light), 32'(ew_tab[p]));
    check("walk", 32'(walk), (p == 6) ? 1 : 0);
    check("ped_ack", 32'(ped_ack), 32'(ack));
    check("timer", 32'(dut.timer_q), rem - 1);
    check("pending", 32'(dut.pending_q), 32'(pend));
    if (ped_ack) ack_cnt++;
    if (walk) walk_cnt++;
    if (prev_state == 3'd5 && state_o == 3'd0) entries.push_back(cyc);
    prev_state = state_o;
  endtask

  task automatic step(input bit r, input bit tk, input bit pr);
    @(negedge clk_in);
    check_all();
    rst_n = r; tick_in = tk; ped_req = pr;
    if (!r) begin
      #1;
      check("rst_ns", 32'(ns_light), 32'(3'b001));
      check("rst_ew", 32'(ew_light), 32'(3'b100));
      check("rst_walk", 32'(walk), 0);
    end
    model_step(r, tk, pr);
    cyc++;
  endtask

  function automatic bit per();
    return (cyc % 4) >= 2;
  endfunction

  task automatic run_until_phase(input int ph, input string tag);
    int n;
    n = 0;
    while (p != ph && n < 300) begin step(1, per(), 0); n++; end
    if (p != ph) check({tag, "_timeout"}, 32'(p), ph);
  endtask

  initial begin
    bit tk, pr;
    int hold, n;
    plen   = '{G, Y, A, G, Y, A, W};
    ns_tab = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
    ew_tab = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b100};
    samp = '{0, 0, 0};
    p = 0; rem = G; pend = 0; ack = 0; cyc = 0; prev_state = 3'd0;

    // reset with tick_in toggling
    for (int i = 0; i < 6; i++) step(0, cyc[0], 0);

    // tick_in held high after release: exactly one tick
    for (int i = 0; i < 40; i++) step(1, 1, 0);
    @(negedge clk_in);
    check("held_tick_state", 32'(state_o), 0);
    check("held_tick_timer", 32'(dut.timer_q), 3);

    // full cycle without pedestrian
    entries.delete(); walk_cnt = 0;
    for (int i = 0; i < 200; i++) step(1, per(), 0);
    if (entries.size() >= 2) check("cycle_len", entries[1] - entries[0], 64);
    else check("cycle_entries", entries.size(), 2);
    check("no_walk", walk_cnt, 0);

    // pedestrian pulse during EW_GREEN
    run_until_phase(3, "wait_ewg");
    ack_cnt = 0; walk_cnt = 0;
    step(1, per(), 1);
    run_until_phase(6, "wait_walk");
    run_until_phase(0, "wait_nsg");
    check("ped_ack_once", ack_cnt, 1);
    check("walk_clocks", walk_cnt, W * 4);

    // held request and requests during WALK
    ack_cnt = 0;
    for (int i = 0; i < 30; i++) step(1, per(), 1);
    check("held_req_ack", ack_cnt, 1);
    run_until_phase(6, "wait_walk2");
    ack_cnt = 0;
    n = 0;
    while (p == 6 && n < 100) begin step(1, per(), 1); n++; end
    check("walk_req_ack", ack_cnt, 0);
    walk_cnt = 0;
    for (int i = 0; i < 70; i++) step(1, per(), 0);
    check("walk_req_skip", walk_cnt, 0);

    // request on the ALLRED2 exit edge
    n = 0;
    while (!(p == 5 && rem == 1 && tick_next()) && n < 300) begin step(1, per(), 0); n++; end
    check("same_edge_found", (p == 5 && rem == 1) ? 1 : 0, 1);
    walk_cnt = 0;
    step(1, per(), 1);
    run_until_phase(5, "wait_ar2");
    check("same_edge_deferred", walk_cnt, 0);
    run_until_phase(0, "wait_after_walk");
    check("same_edge_served", walk_cnt, W * 4);

    // reset during EW_YELLOW with a request pending
    run_until_phase(3, "wait_ewg2");
    step(1, per(), 1);
    run_until_phase(4, "wait_ewy");
    check("pend_before_rst", 32'(dut.pending_q), 1);
    step(0, per(), 0);
    step(0, per(), 0);
    walk_cnt = 0;
    for (int i = 0; i < 80; i++) step(1, per(), 0);
    check("rst_discard_walk", walk_cnt, 0);

    // randomized traffic, requests and occasional resets
    hold = 0; tk = 0; pr = 0;
    for (int i = 0; i < 2500; i++) begin
      if (hold == 0) begin tk = ~tk; hold = $urandom_range(1, 6); end
      hold--;
      if ($urandom_range(0, 9) == 0) pr = ~pr;
      if ($urandom_range(0, 499) == 0) step(0, tk, pr);
      else step(1, tk, pr);
    end
    @(negedge clk_in);
    check_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_light_fsm.md
# traffic_light_fsm

Two-road traffic light controller with pedestrian phase. It sits directly downstream of the clock divider: the divider's slow output enters as `tick_in`, and the block runs entirely on the fast system clock. `tick_in` is synchronized and edge-detected into a one-cycle tick, and a Moore FSM advances phase timers on each tick. Light and walk outputs drive the board LEDs.

## Interface
- `GREEN_T`, 5: ticks spent in each green phase (≥1)
- `YELLOW_T`, 2: ticks spent in each yellow phase (≥1)
- `ALLRED_T`, 1: ticks spent in each all-red clearance phase (≥1)
- `WALK_T`, 4: ticks spent in the pedestrian walk phase (≥1)
- `CW`, 4: phase timer width; every `*_T` must be ≤ 2^CW
- `clk_in`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `tick_in`  in  1  divided clock from the divider, treated as an asynchronous level
- `ped_req`  in  1  pedestrian request, synchronous to `clk_in`, level
- `ns_light`  out  3  north-south lamps {R,Y,G}
- `ew_light`  out  3  east-west lamps {R,Y,G}
- `walk`  out  1  pedestrian walk lamp
- `ped_ack`  out  1  one-cycle pulse when a request is latched
- `state_o`  out  3  current state encoding, for debug

## Operation
- **Tick generation:** `tick_in` passes through 2-flop synchronizer s1→s2, and s3 holds the previous s2. `tick = s2 & ~s3`. This gives exactly one tick per rising edge of `tick_in`. A `tick_in` held high produces a single tick.
- **State sequence:**
  - NS_GREEN → NS_YELLOW → ALLRED1 → EW_GREEN → EW_YELLOW → ALLRED2.
  - From ALLRED2: go to WALK if `pending`=1, else NS_GREEN. WALK → NS_GREEN.
- **Phase timer:**
  - On entry to a state, the timer loads that state's `T-1`.
  - On each tick with timer≠0, the timer decrements.
  - On a tick with timer==0, the FSM transitions.
  - Each state therefore lasts exactly T ticks.
- **Outputs (Moore decode of the state register):**
  - NS_GREEN: ns=001, ew=100
  - NS_YELLOW: ns=010, ew=100
  - EW_GREEN: ns=100, ew=001
  - EW_YELLOW: ns=100, ew=010
  - ALLRED1, ALLRED2, WALK: ns=100, ew=100
  - `walk`=1 only in WALK.
- **Pedestrian request:**
  - When `ped_req`=1, `pending`=0 and state≠WALK, the block sets `pending` and pulses `ped_ack` for one cycle.
  - `ped_req` is ignored while `pending`=1 or while in WALK. No ack is issued and no second walk is queued.
  - `pending` clears on the transition out of WALK.
- **Simultaneous events:** the ALLRED2 exit decision uses the registered `pending` only. A `ped_req` arriving on the same edge as the ALLRED2 exit sets `pending`, and that request is served after the next ALLRED2.
- **Reset values:**
  - Sequential: state=NS_GREEN, timer=`GREEN_T-1`, s1/s2/s3=0, `pending`=0, `ped_ack`=0.
  - Outputs: ns=001, ew=100, walk=0.
  - A reset asserted mid-operation discards any pending request and the remaining phase time.

## Timing
- **Tick latency:** `tick_in` is first sampled high at edge E0. s2=1 after E1, and tick is high during the cycle after E1. State and timer update at E2.
- **Light change:** lights change 3 `clk_in` edges after `tick_in` rises, when the timer is 0.
- **`ped_ack`:** registered, high in the cycle after the edge that samples `ped_req`.
- **Tick rate:** with the divider at DIV=2, `tick_in` rises every 4 `clk_in` cycles. The full no-pedestrian cycle is 2·(GREEN_T+YELLOW_T+ALLRED_T) = 16 ticks = 64 clocks.
- **Width rule:** the timer is CW bits and is never loaded with more than 2^CW−1. A `*_T` of 0 is illegal; it is elaborated as 1.

## Structure
- Package `tl_pkg` holds:
  - state encodings (NS_GREEN=0 … ALLRED2=5, WALK=6)
  - lamp constants `LAMP_R`=100, `LAMP_Y`=010, `LAMP_G`=001
- Sub-module `tick_sync` contains the synchronizer and rising-edge detector. Ports: `clk_in`, `rst_n`, `async_in`, `pulse_out`.
- The FSM, phase timer and pedestrian latch stay in `traffic_light_fsm`.

## Test plan
- **Reset:** `rst_n`=0 with `tick_in` toggling → ns=001, ew=100, walk=0, `state_o`=0, `ped_ack`=0. Holding `tick_in`=1 for 40 cycles after release → exactly one tick, timer drops from 4 to 3, still NS_GREEN.
- **Full cycle, no pedestrian:** `tick_in` period 4 clocks, defaults → phase lengths 5/2/1/5/2/1 ticks. NS_GREEN re-entered 64 clocks after the first tick; WALK never entered.
- **Pedestrian during EW_GREEN:** `ped_req` pulsed for 1 cycle → `ped_ack` high for exactly 1 cycle. After ALLRED2: WALK for 4 ticks with walk=1, ns=ew=100, then NS_GREEN with `pending`=0.
- **Held and repeated requests:** `ped_req` held for 30 cycles → a single `ped_ack`. `ped_req` asserted during WALK → no ack, and the next cycle passes through without WALK.
- **Same-edge request:** `ped_req` on the ALLRED2→NS_GREEN edge → NS_GREEN is entered, and WALK occurs only after the next ALLRED2.
- **Reset mid-operation:** `rst_n` pulsed low during EW_YELLOW with `pending`=1 → immediately ns=001, ew=100. The following cycle skips WALK, and the tick→state-change latency is 3 edges.
